// File: rtl/legv8_pkg.sv
// ----------------------------------------------------------------------------
// legv8_pkg
// Shared LEGv8 datapath definitions. The register file, ALU and decoder all
// import this package so that register addressing and data width stay in one
// place. ALUControl encodings are added here alongside the ALU.
//   ADDR_W  : architectural register address width
//   XZR_IDX : index of the hardwired zero register
//   DATA_W  : architectural data width
// ----------------------------------------------------------------------------
package legv8_pkg;

   localparam int ADDR_W = 5;
   localparam logic [ADDR_W-1:0] XZR_IDX = 5'd31;
   localparam int DATA_W = 64;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] word_t;

endpackage : legv8_pkg

// File: rtl/regfile_rdport.sv
// ----------------------------------------------------------------------------
// regfile_rdport
// Combinational read-port mux for the register file. Priority:
//   1. address XZR               -> zero (wins even over a matching bypass)
//   2. bypass enabled and wa==ra -> write data of the current cycle
//   3. otherwise                 -> stored register value
// Ports:
//   ra     : read address
//   stored : contents of register ra (already zero for XZR)
//   byp_en : forwarding allowed this cycle (BYPASS set, out of reset, we3 high)
//   wa, wd : write address / data of the current cycle
//   rd     : read data
// ----------------------------------------------------------------------------
module regfile_rdport
   import legv8_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [4:0]       ra,
   input  logic [WIDTH-1:0] stored,
   input  logic             byp_en,
   input  logic [4:0]       wa,
   input  logic [WIDTH-1:0] wd,
   output logic [WIDTH-1:0] rd
);

   // Read-data select: XZR first, then write-through, then storage.
   always_comb begin
      rd = stored;
      if (ra == XZR_IDX) begin
         rd = '0;
      end else if (byp_en && (wa == ra)) begin
         rd = wd;
      end else begin
         rd = stored;
      end
   end

endmodule : regfile_rdport

// File: rtl/regfile.sv
// ----------------------------------------------------------------------------
// regfile
// 32 x WIDTH LEGv8 integer register file, two combinational read ports and
// one synchronous write port. X31 is XZR: it has no storage, reads as zero
// and swallows writes. An active-low asynchronous reset loads each register
// with its own index.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   ra1, rd1 : read port 1 (Rn, ALU operand a)
//   ra2, rd2 : read port 2 (Rm/Rt, operand b / store data)
//   we3, wa3, wd3 : write enable / address / data (writeback)
// ----------------------------------------------------------------------------
module regfile
   import legv8_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ra1,
   input  logic [4:0]       ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   input  logic             we3,
   input  logic [4:0]       wa3,
   input  logic [WIDTH-1:0] wd3
);

   // Storage for X0..X30 only; XZR has no flops.
   logic [WIDTH-1:0] regs_r [NREGS-1];

   // Read view covering every 5-bit address, with the XZR slot tied to zero,
   // so the read index never runs past the storage array.
   logic [WIDTH-1:0] rview_s [NREGS];

   logic byp_en_s;

   // Register storage: async reset to own index, otherwise gated write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS - 1; i++) begin
            regs_r[i] <= WIDTH'(i);
         end
      end else begin
         for (int i = 0; i < NREGS - 1; i++) begin
            if (we3 && (wa3 == ADDR_W'(i)) && (wa3 != XZR_IDX)) begin
               regs_r[i] <= wd3;
            end
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < NREGS - 1; g++) begin : g_rview
         assign rview_s[g] = regs_r[g];
      end
   endgenerate
   assign rview_s[NREGS-1] = '0;

   // Forwarding is suppressed while reset is held, since the write is ignored.
   assign byp_en_s = (BYPASS != 0) && reset && we3;

   regfile_rdport #(.WIDTH(WIDTH)) u_rdport1 (
      .ra     (ra1),
      .stored (rview_s[ra1]),
      .byp_en (byp_en_s),
      .wa     (wa3),
      .wd     (wd3),
      .rd     (rd1)
   );

   regfile_rdport #(.WIDTH(WIDTH)) u_rdport2 (
      .ra     (ra2),
      .stored (rview_s[ra2]),
      .byp_en (byp_en_s),
      .wa     (wa3),
      .wd     (wd3),
      .rd     (rd2)
   );

endmodule : regfile

// File: tb/tb_regfile.sv
// ----------------------------------------------------------------------------
// tb_regfile
// Drives one BYPASS=1 and one BYPASS=0 register file from the same inputs and
// compares their read ports against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_regfile;

   logic        clk;
   logic        reset;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic        we3;
   logic [4:0]  wa3;
   logic [63:0] wd3;
   logic [63:0] rd1_b;
   logic [63:0] rd2_b;
   logic [63:0] rd1_n;
   logic [63:0] rd2_n;

   int checks   = 0;
   int failures = 0;

   regfile #(.WIDTH(64), .NREGS(32), .BYPASS(1)) dut_b (
      .clk   (clk),
      .reset (reset),
      .ra1   (ra1),
      .ra2   (ra2),
      .rd1   (rd1_b),
      .rd2   (rd2_b),
      .we3   (we3),
      .wa3   (wa3),
      .wd3   (wd3)
   );

   regfile #(.WIDTH(64), .NREGS(32), .BYPASS(0)) dut_n (
      .clk   (clk),
      .reset (reset),
      .ra1   (ra1),
      .ra2   (ra2),
      .rd1   (rd1_n),
      .rd2   (rd2_n),
      .we3   (we3),
      .wa3   (wa3),
      .wd3   (wd3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // One cycle of directed stimulus: inputs applied after the falling edge,
   // outputs checked before the next rising edge commits any write.
   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [63:0] wd;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [63:0] e1;   // BYPASS=1 rd1
      logic [63:0] e2;   // BYPASS=1 rd2
      logic [63:0] n1;   // BYPASS=0 rd1
      logic [63:0] n2;   // BYPASS=0 rd2
   } vec_t;

   vec_t vecs [12];

   function automatic logic [63:0] rst_val(input logic [4:0] a);
      return (a == 5'd31) ? 64'd0 : {59'd0, a};
   endfunction

   initial begin
      logic [4:0] a;
      logic [4:0] b;

      vecs[0]  = '{1'b1, 5'd5,  64'hDEAD_BEEF_0000_0001, 5'd5,  5'd6,
                   64'hDEAD_BEEF_0000_0001, 64'd6, 64'd5, 64'd6};
      vecs[1]  = '{1'b0, 5'd0,  64'd0, 5'd5, 5'd5,
                   64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001,
                   64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001};
      vecs[2]  = '{1'b0, 5'd0,  64'd0, 5'd6, 5'd5,
                   64'd6, 64'hDEAD_BEEF_0000_0001, 64'd6, 64'hDEAD_BEEF_0000_0001};
      vecs[3]  = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 5'd31,
                   64'd1, 64'd0, 64'd1, 64'd0};
      vecs[4]  = '{1'b0, 5'd0,  64'd0, 5'd31, 5'd31,
                   64'd0, 64'd0, 64'd0, 64'd0};
      vecs[5]  = '{1'b1, 5'd10, 64'h1234, 5'd10, 5'd11,
                   64'h1234, 64'd11, 64'd10, 64'd11};
      vecs[6]  = '{1'b0, 5'd0,  64'd0, 5'd10, 5'd10,
                   64'h1234, 64'h1234, 64'h1234, 64'h1234};
      vecs[7]  = '{1'b0, 5'd3,  64'hAAAA, 5'd3, 5'd3,
                   64'd3, 64'd3, 64'd3, 64'd3};
      vecs[8]  = '{1'b0, 5'd0,  64'd0, 5'd3, 5'd2,
                   64'd3, 64'd2, 64'd3, 64'd2};
      vecs[9]  = '{1'b1, 5'd12, 64'hCAFE, 5'd12, 5'd12,
                   64'hCAFE, 64'hCAFE, 64'd12, 64'd12};
      vecs[10] = '{1'b1, 5'd12, 64'hBEEF, 5'd12, 5'd31,
                   64'hBEEF, 64'd0, 64'hCAFE, 64'd0};
      vecs[11] = '{1'b0, 5'd0,  64'd0, 5'd12, 5'd10,
                   64'hBEEF, 64'h1234, 64'hBEEF, 64'h1234};

      reset = 1'b1;
      ra1   = 5'd0;
      ra2   = 5'd0;
      we3   = 1'b0;
      wa3   = 5'd0;
      wd3   = 64'd0;
      #2;
      reset = 1'b0;

      // Reset held: sweep both ports while attempting writes and bypasses.
      for (int i = 0; i < 32; i++) begin
         a   = 5'(i);
         b   = 5'(31 - i);
         ra1 = a;
         ra2 = b;
         we3 = 1'b1;
         wa3 = a;
         wd3 = 64'hFFFF_FFFF_FFFF_FFFF;
         #3;
         chk($sformatf("rst_rd1_byp[%0d]", i), rd1_b, rst_val(a));
         chk($sformatf("rst_rd2_byp[%0d]", i), rd2_b, rst_val(b));
         chk($sformatf("rst_rd1_nob[%0d]", i), rd1_n, rst_val(a));
      end

      // Release reset with no writes; contents must be unchanged.
      @(negedge clk);
      reset = 1'b1;
      we3   = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         a   = 5'(i);
         ra1 = a;
         ra2 = a;
         #1;
         chk($sformatf("post_rd1_byp[%0d]", i), rd1_b, rst_val(a));
         chk($sformatf("post_rd2_nob[%0d]", i), rd2_n, rst_val(a));
      end

      // Table-driven vectors, one cycle each.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         we3 = vecs[i].we;
         wa3 = vecs[i].wa;
         wd3 = vecs[i].wd;
         ra1 = vecs[i].a1;
         ra2 = vecs[i].a2;
         #1;
         chk($sformatf("vec%0d_rd1_byp", i), rd1_b, vecs[i].e1);
         chk($sformatf("vec%0d_rd2_byp", i), rd2_b, vecs[i].e2);
         chk($sformatf("vec%0d_rd1_nob", i), rd1_n, vecs[i].n1);
         chk($sformatf("vec%0d_rd2_nob", i), rd2_n, vecs[i].n2);
      end

      // Async reset mid-operation: write X7, then drop reset between edges.
      @(negedge clk);
      we3 = 1'b1;
      wa3 = 5'd7;
      wd3 = 64'h77;
      ra1 = 5'd7;
      ra2 = 5'd12;
      @(posedge clk);
      #1;
      chk("x7_written_nob", rd1_n, 64'h77);
      we3 = 1'b0;
      #1;
      chk("x7_stored_byp", rd1_b, 64'h77);
      chk("x12_before_rst", rd2_n, 64'hBEEF);
      #1;
      reset = 1'b0;
      #1;
      chk("async_rst_x7_byp", rd1_b, 64'd7);
      chk("async_rst_x7_nob", rd1_n, 64'd7);
      chk("async_rst_x12", rd2_b, 64'd12);

      // Write attempt while reset is low must be lost and not forwarded.
      we3 = 1'b1;
      wa3 = 5'd7;
      wd3 = 64'h99;
      #1;
      chk("rst_no_bypass", rd1_b, 64'd7);
      @(posedge clk);
      #1;
      chk("rst_write_lost_byp", rd1_b, 64'd7);
      chk("rst_write_lost_nob", rd1_n, 64'd7);

      // Release reset; X7 keeps its reset value.
      @(negedge clk);
      we3   = 1'b0;
      reset = 1'b1;
      ra2   = 5'd10;
      #1;
      chk("rel_x7_byp", rd1_b, 64'd7);
      chk("rel_x10_nob", rd2_n, 64'd10);
      @(posedge clk);
      #1;
      chk("rel_x7_after_edge", rd1_n, 64'd7);

      // Writes resume after reset release.
      @(negedge clk);
      we3 = 1'b1;
      wa3 = 5'd7;
      wd3 = 64'h5555;
      #1;
      chk("resume_pre_nob", rd1_n, 64'd7);
      @(negedge clk);
      we3 = 1'b0;
      #1;
      chk("resume_post_nob", rd1_n, 64'h5555);
      chk("resume_post_byp", rd1_b, 64'h5555);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_regfile
